// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use bubbles, branch/jump flushes and MDU occupancy stalls.
// Optional HAZARD_STATS_EN builds 32-bit stall-cycle and redirect counters; otherwise those ports read 0.
module hazard_ctrl #(
  parameter int MDU_CYCLES = 32,
  parameter int CNT_W      = 6
) (
  input  logic        Clk,
  input  logic        Rst_n,
  input  logic        MemRead_EX,
  input  logic [4:0]  Rt_EX,
  input  logic [4:0]  Rs_ID,
  input  logic [4:0]  Rt_ID,
  input  logic        UseRs_ID,
  input  logic        UseRt_ID,
  input  logic        BranchTaken_EX,
  input  logic        Jump_EX,
  input  logic        MduStart_EX,
  input  logic        MduUse_ID,
  output logic        stall_PC,
  output logic        stall_IF_ID,
  output logic        flush_IF_ID,
  output logic        stall_ID_EX,
  output logic        flush_ID_EX,
  output logic        loaduse_out,
  output logic        mdu_busy,
  output logic [31:0] StallCycles,
  output logic [31:0] FlushCount
);

  // state | meaning
  // RUN   | no bubble pending, MDU idle
  // LU    | load-use bubble issued last cycle; lu suppressed for this cycle
  // BUSY  | MDU counter running
  typedef enum logic [1:0] {RUN, LU, BUSY} state_t;

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   cnt, cnt_nxt;
  logic               redirect, lu, mduhaz, busy_int;

  assign busy_int = (cnt != '0);
  assign redirect = BranchTaken_EX | Jump_EX;
  assign lu       = MemRead_EX && (Rt_EX != 5'd0) &&
                    ((UseRs_ID && (Rs_ID == Rt_EX)) || (UseRt_ID && (Rt_ID == Rt_EX))) &&
                    (state != LU);
  assign mduhaz   = MduUse_ID & (busy_int | MduStart_EX);

  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      state <= RUN;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // The MDU start belongs to the older EX instruction, so it is honoured even under a redirect.
  always_comb begin
    cnt_nxt = busy_int ? cnt - CNT_W'(1) : '0;
    if (MduStart_EX) cnt_nxt = CNT_W'(MDU_CYCLES - 1);

    state_nxt = state;
    if (MduStart_EX)
      state_nxt = BUSY;
    else if (!redirect && lu)
      state_nxt = LU;
    else if (state == LU || state == BUSY)
      state_nxt = (cnt_nxt != '0) ? BUSY : RUN;
  end

  always_comb begin
    stall_PC    = 1'b0;
    stall_IF_ID = 1'b0;
    flush_IF_ID = 1'b0;
    stall_ID_EX = 1'b0;
    flush_ID_EX = 1'b0;
    loaduse_out = 1'b0;
    mdu_busy    = 1'b0;
    if (!Rst_n) begin
      flush_IF_ID = 1'b1;
      flush_ID_EX = 1'b1;
    end else begin
      mdu_busy = busy_int;
      if (redirect) begin
        flush_IF_ID = 1'b1;
        flush_ID_EX = 1'b1;
      end else if (lu) begin
        stall_PC    = 1'b1;
        stall_IF_ID = 1'b1;
        flush_ID_EX = 1'b1;
        loaduse_out = 1'b1;
      end else if (mduhaz) begin
        stall_PC    = 1'b1;
        stall_IF_ID = 1'b1;
        flush_ID_EX = 1'b1;
      end
    end
  end

`ifdef HAZARD_STATS_EN
  logic [31:0] stall_cnt, flush_cnt;

  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (stall_PC) stall_cnt <= stall_cnt + 32'd1;
      if (redirect) flush_cnt <= flush_cnt + 32'd1;
    end
  end

  assign StallCycles = Rst_n ? stall_cnt : 32'b0;
  assign FlushCount  = Rst_n ? flush_cnt : 32'b0;
`else
  assign StallCycles = 32'b0;
  assign FlushCount  = 32'b0;
`endif

endmodule
